// File: rtl/ysyx_22040895_dmem_ctrl_pkg.sv
// Shared types for the data-memory access controller.
// Holds the access size and FSM state encodings, the timeout default and a strobe helper.
package ysyx_22040895_dmem_ctrl_pkg;

    localparam int XLEN_DEF    = 64;
    localparam int TIMEOUT_DEF = 255;
    localparam int BUS_BYTES   = 8;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } sz_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10,
        DONE = 2'b11
    } state_e;

    // Strobe pattern for an access of the given size at lane 0.
    function automatic logic [BUS_BYTES-1:0] strb_base(input sz_e sz);
        logic [BUS_BYTES-1:0] s;
        unique case (sz)
            SZ_B:    s = 8'h01;
            SZ_H:    s = 8'h03;
            SZ_W:    s = 8'h0F;
            SZ_D:    s = 8'hFF;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ysyx_22040895_dmem_ctrl_if.sv
// Data-memory bus: valid/ready request channel plus a response channel.
// master = controller side, slave = memory side.
interface ysyx_22040895_dmem_ctrl_if #(
    parameter int XLEN = 64
);
    logic            req_valid_o;
    logic            req_ready_i;
    logic [XLEN-1:0] req_addr_o;
    logic            req_we_o;
    logic [7:0]      req_wstrb_o;
    logic [XLEN-1:0] req_wdata_o;
    logic            rsp_valid_i;
    logic [XLEN-1:0] rsp_data_i;
    logic            rsp_err_i;

    modport master (
        output req_valid_o,
        input  req_ready_i,
        output req_addr_o,
        output req_we_o,
        output req_wstrb_o,
        output req_wdata_o,
        input  rsp_valid_i,
        input  rsp_data_i,
        input  rsp_err_i
    );

    modport slave (
        input  req_valid_o,
        output req_ready_i,
        input  req_addr_o,
        input  req_we_o,
        input  req_wstrb_o,
        input  req_wdata_o,
        output rsp_valid_i,
        output rsp_data_i,
        output rsp_err_i
    );
endinterface

// File: rtl/ysyx_22040895_dmem_align.sv
// Lane logic: store strobe/data shifting, load extraction with extension, misalign detect.
// st_* = live request side, ld_* = latched side of the in-flight load.
module ysyx_22040895_dmem_align
    import ysyx_22040895_dmem_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      st_off,
    input  sz_e             st_size,
    input  logic [XLEN-1:0] st_data,
    input  logic [2:0]      ld_off,
    input  sz_e             ld_size,
    input  logic            ld_sign,
    input  logic [XLEN-1:0] ld_raw,
    output logic            misalign,
    output logic [7:0]      st_strb,
    output logic [XLEN-1:0] st_lane,
    output logic [XLEN-1:0] ld_data
);
    logic [XLEN-1:0] ld_sh;

    always_comb begin
        misalign = 1'b0;
        unique case (st_size)
            SZ_B:    misalign = 1'b0;
            SZ_H:    misalign = st_off[0];
            SZ_W:    misalign = |st_off[1:0];
            SZ_D:    misalign = |st_off;
            default: misalign = 1'b0;
        endcase
    end

    assign st_strb = strb_base(st_size) << st_off;
    assign st_lane = st_data << {st_off, 3'b000};

    assign ld_sh = ld_raw >> {ld_off, 3'b000};

    always_comb begin
        ld_data = ld_sh;
        unique case (ld_size)
            SZ_B: ld_data = {{(XLEN-8){ld_sign & ld_sh[7]}}, ld_sh[7:0]};
            SZ_H: ld_data = {{(XLEN-16){ld_sign & ld_sh[15]}}, ld_sh[15:0]};
            SZ_W: ld_data = {{(XLEN-32){ld_sign & ld_sh[31]}}, ld_sh[31:0]};
            SZ_D: ld_data = ld_sh;
            default: ld_data = ld_sh;
        endcase
    end

endmodule

// File: rtl/ysyx_22040895_dmem_ctrl.sv
// Data-memory access controller: runs one bus transaction per memory-stage access.
// Ports: clk/rst, memory-stage m* inputs, rmdata/stall/misalign/err outputs, bus master.
module ysyx_22040895_dmem_ctrl
    import ysyx_22040895_dmem_ctrl_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mce_i,
    input  logic            mwe_i,
    input  logic [1:0]      munit_i,
    input  logic            msign_i,
    input  logic [XLEN-1:0] maddr_i,
    input  logic [XLEN-1:0] wmdata_i,
    output logic [XLEN-1:0] rmdata_o,
    output logic            stall_o,
    output logic            misalign_o,
    output logic            err_o,
    ysyx_22040895_dmem_ctrl_if.master bus
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    state_e          state;
    state_e          state_nx;
    logic [CW-1:0]   cnt;
    logic [2:0]      off_q;
    sz_e             size_q;
    logic            sign_q;
    logic            we_q;

    logic            mis;
    logic [7:0]      st_strb;
    logic [XLEN-1:0] st_lane;
    logic [XLEN-1:0] ld_data;
    logic            start;
    logic            timeout;

    ysyx_22040895_dmem_align #(
        .XLEN (XLEN)
    ) u_align (
        .st_off   (maddr_i[2:0]),
        .st_size  (sz_e'(munit_i)),
        .st_data  (wmdata_i),
        .ld_off   (off_q),
        .ld_size  (size_q),
        .ld_sign  (sign_q),
        .ld_raw   (bus.rsp_data_i),
        .misalign (mis),
        .st_strb  (st_strb),
        .st_lane  (st_lane),
        .ld_data  (ld_data)
    );

    assign start   = (state == IDLE) & mce_i & ~mis;
    // Last waiting cycle: counter is about to reach TIMEOUT_CYC.
    assign timeout = (cnt == CW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_nx   = state;
        stall_o    = 1'b0;
        misalign_o = 1'b0;
        unique case (state)
            IDLE: begin
                misalign_o = mce_i & mis;
                stall_o    = start;
                if (start) state_nx = REQ;
            end
            REQ: begin
                stall_o = 1'b1;
                if (bus.req_ready_i) state_nx = RESP;
            end
            RESP: begin
                stall_o = 1'b1;
                if (bus.rsp_valid_i || timeout) state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            cnt             <= '0;
            off_q           <= 3'b000;
            size_q          <= SZ_B;
            sign_q          <= 1'b0;
            we_q            <= 1'b0;
            rmdata_o        <= '0;
            err_o           <= 1'b0;
            bus.req_valid_o <= 1'b0;
            bus.req_addr_o  <= '0;
            bus.req_we_o    <= 1'b0;
            bus.req_wstrb_o <= 8'h00;
            bus.req_wdata_o <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        off_q           <= maddr_i[2:0];
                        size_q          <= sz_e'(munit_i);
                        sign_q          <= msign_i;
                        we_q            <= mwe_i;
                        bus.req_valid_o <= 1'b1;
                        bus.req_addr_o  <= {maddr_i[XLEN-1:3], 3'b000};
                        bus.req_we_o    <= mwe_i;
                        bus.req_wstrb_o <= mwe_i ? st_strb : 8'h00;
                        bus.req_wdata_o <= st_lane;
                    end
                end
                REQ: begin
                    if (bus.req_ready_i) begin
                        bus.req_valid_o <= 1'b0;
                        cnt             <= '0;
                    end
                end
                RESP: begin
                    if (bus.rsp_valid_i) begin
                        rmdata_o <= we_q ? '0 : ld_data;
                        err_o    <= bus.rsp_err_i;
                    end else if (timeout) begin
                        rmdata_o <= '0;
                        err_o    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040895_dmem_ctrl.sv
// Self-checking bench for the data-memory access controller.
// Directed table, randomized transactions vs a byte-level model, timeout and reset sequences.
module tb_ysyx_22040895_dmem_ctrl;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        mce_i;
    logic        mwe_i;
    logic [1:0]  munit_i;
    logic        msign_i;
    logic [63:0] maddr_i;
    logic [63:0] wmdata_i;
    logic [63:0] rmdata_o;
    logic        stall_o;
    logic        misalign_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    ysyx_22040895_dmem_ctrl_if #(.XLEN(64)) bus ();

    ysyx_22040895_dmem_ctrl #(
        .XLEN        (64),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mce_i      (mce_i),
        .mwe_i      (mwe_i),
        .munit_i    (munit_i),
        .msign_i    (msign_i),
        .maddr_i    (maddr_i),
        .wmdata_i   (wmdata_i),
        .rmdata_o   (rmdata_o),
        .stall_o    (stall_o),
        .misalign_o (misalign_o),
        .err_o      (err_o),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        rerr;
        int          rdly;
        int          sdly;
        logic        mis;
        logic [7:0]  strb;
        logic [63:0] lane;
        logic [63:0] rmd;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Byte-level reference: access covers n = 2**sz bytes starting at byte addr[2:0].
    function automatic void model(input logic we, input logic [1:0] sz,
                                  input logic sg, input logic [63:0] addr,
                                  input logic [63:0] wdata,
                                  input logic [63:0] rdata,
                                  output logic mis, output logic [7:0] strb,
                                  output logic [63:0] lane,
                                  output logic [63:0] rmd);
        int n;
        int off;
        logic [63:0] v;
        n   = 1 << sz;
        off = int'(addr[2:0]);
        mis = (off % n) != 0;
        strb = we ? 8'(((1 << n) - 1) << off) : 8'h00;
        lane = wdata << (8 * off);
        v = 64'd0;
        if (!mis) begin
            for (int i = 0; i < n; i++)
                v = v | (64'(rdata[8*(off+i) +: 8]) << (8 * i));
            if (sg && n < 8 && v[8*n-1])
                v = v | ~((64'd1 << (8 * n)) - 64'd1);
        end
        rmd = we ? 64'd0 : v;
    endfunction

    task automatic run_txn(input vec_t v);
        int st;
        mce_i    = 1'b1;
        mwe_i    = v.we;
        munit_i  = v.sz;
        msign_i  = v.sg;
        maddr_i  = v.addr;
        wmdata_i = v.wdata;
        #1;
        chk("misalign", misalign_o, v.mis);
        if (v.mis) begin
            chk("mis_stall", stall_o, 1'b0);
            step();
            chk("mis_noreq", bus.req_valid_o, 1'b0);
            mce_i = 1'b0;
            #1;
            chk("mis_idle_stall", stall_o, 1'b0);
            return;
        end
        chk("idle_noreq", bus.req_valid_o, 1'b0);
        st = stall_o ? 1 : 0;
        step();
        for (int k = 0; k <= v.rdly; k++) begin
            bus.req_ready_i = (k == v.rdly);
            bus.rsp_valid_i = (k != v.rdly);
            bus.rsp_data_i  = 64'hDEAD_0000_BEEF_0000;
            bus.rsp_err_i   = 1'b1;
            #1;
            chk("req_valid", bus.req_valid_o, 1'b1);
            chk("req_addr", bus.req_addr_o, v.addr & ~64'h7);
            chk("req_we", bus.req_we_o, v.we);
            chk("req_wstrb", bus.req_wstrb_o, v.strb);
            if (v.we) chk("req_wdata", bus.req_wdata_o, v.lane);
            if (stall_o) st++;
            step();
        end
        bus.req_ready_i = 1'b0;
        for (int k = 0; k <= v.sdly; k++) begin
            bus.rsp_valid_i = (k == v.sdly);
            bus.rsp_data_i  = (k == v.sdly) ? v.rdata : 64'h5A5A_5A5A_5A5A_5A5A;
            bus.rsp_err_i   = (k == v.sdly) ? v.rerr : 1'b1;
            #1;
            chk("resp_noreq", bus.req_valid_o, 1'b0);
            if (stall_o) st++;
            step();
        end
        bus.rsp_valid_i = 1'b0;
        bus.rsp_err_i   = 1'b0;
        #1;
        chk("done_stall", stall_o, 1'b0);
        chk("rmdata", rmdata_o, v.rmd);
        chk("err", err_o, v.rerr);
        chk("stall_cycles", 64'(st), 64'(3 + v.rdly + v.sdly));
        step();
        mce_i = 1'b0;
        #1;
        chk("idle_stall", stall_o, 1'b0);
        chk("hold_rmdata", rmdata_o, v.rmd);
    endtask

    vec_t tbl[9];
    vec_t rv;
    int   n;

    initial begin
        tbl[0] = '{1'b1, 2'd0, 1'b0, 64'h8000_0003, 64'hAB, 64'h0, 1'b0, 0, 0,
                   1'b0, 8'h08, 64'hAB00_0000, 64'h0};
        tbl[1] = '{1'b0, 2'd1, 1'b1, 64'h8000_0006, 64'h0,
                   64'h8001_0000_0000_0000, 1'b0, 1, 1,
                   1'b0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001};
        tbl[2] = '{1'b0, 2'd1, 1'b0, 64'h8000_0006, 64'h0,
                   64'h8001_0000_0000_0000, 1'b0, 0, 2,
                   1'b0, 8'h00, 64'h0, 64'h0000_0000_0000_8001};
        tbl[3] = '{1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'h0, 64'h0, 1'b0, 0, 0,
                   1'b1, 8'h00, 64'h0, 64'h0};
        tbl[4] = '{1'b0, 2'd3, 1'b1, 64'h8000_0008, 64'h0,
                   64'h1122_3344_5566_7788, 1'b0, 0, 0,
                   1'b0, 8'h00, 64'h0, 64'h1122_3344_5566_7788};
        tbl[5] = '{1'b1, 2'd2, 1'b0, 64'h8000_0004, 64'hDEAD_BEEF, 64'h0, 1'b0,
                   5, 0, 1'b0, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h0};
        tbl[6] = '{1'b0, 2'd0, 1'b1, 64'h8000_0001, 64'h0, 64'h0000_0000_0000_F500,
                   1'b1, 0, 0, 1'b0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FFF5};
        tbl[7] = '{1'b1, 2'd3, 1'b0, 64'h8000_0004, 64'h1234, 64'h0, 1'b0, 0, 0,
                   1'b1, 8'h00, 64'h0, 64'h0};
        tbl[8] = '{1'b0, 2'd2, 1'b0, 64'h8000_0004, 64'h0,
                   64'h8765_4321_0000_0000, 1'b0, 2, 0,
                   1'b0, 8'h00, 64'h0, 64'h0000_0000_8765_4321};

        rst             = 1'b0;
        mce_i           = 1'b0;
        mwe_i           = 1'b0;
        munit_i         = 2'd0;
        msign_i         = 1'b0;
        maddr_i         = 64'h0;
        wmdata_i        = 64'h0;
        bus.req_ready_i = 1'b0;
        bus.rsp_valid_i = 1'b0;
        bus.rsp_data_i  = 64'h0;
        bus.rsp_err_i   = 1'b0;
        step();
        step();
        chk("rst_rmdata", rmdata_o, 64'h0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_req_valid", bus.req_valid_o, 1'b0);
        chk("rst_stall", stall_o, 1'b0);
        rst = 1'b1;
        step();

        foreach (tbl[i]) run_txn(tbl[i]);

        for (int i = 0; i < 60; i++) begin
            rv.we    = 1'($urandom_range(0, 1));
            rv.sz    = 2'($urandom_range(0, 3));
            rv.sg    = 1'($urandom_range(0, 1));
            rv.addr  = 64'h8000_0000 + 64'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0)
                rv.addr = rv.addr & ~64'((1 << rv.sz) - 1);
            rv.wdata = {$urandom, $urandom};
            rv.rdata = {$urandom, $urandom};
            rv.rerr  = ($urandom_range(0, 7) == 0);
            rv.rdly  = $urandom_range(0, 3);
            rv.sdly  = $urandom_range(0, 3);
            model(rv.we, rv.sz, rv.sg, rv.addr, rv.wdata, rv.rdata,
                  rv.mis, rv.strb, rv.lane, rv.rmd);
            if (rv.mis) rv.rerr = 1'b0;
            if (rv.mis) rv.rmd = rmdata_o;
            run_txn(rv);
        end

        // Timeout: load that never gets a response, after a load left rmdata nonzero.
        run_txn(tbl[4]);
        mce_i = 1'b1; mwe_i = 1'b0; munit_i = 2'd3; msign_i = 1'b0;
        maddr_i = 64'h8000_0010;
        bus.req_ready_i = 1'b1;
        step();
        step();
        bus.req_ready_i = 1'b0;
        n = 0;
        #1;
        while (stall_o && n < 1000) begin
            n++;
            step();
        end
        chk("tmo_cycles", 64'(n), 64'(TMO));
        chk("tmo_err", err_o, 1'b1);
        chk("tmo_rmdata", rmdata_o, 64'h0);
        chk("tmo_done_stall", stall_o, 1'b0);
        step();
        mce_i = 1'b0;
        #1;
        chk("tmo_idle_stall", stall_o, 1'b0);

        // Reset while waiting in RESP for a store; a late response is ignored.
        run_txn(tbl[4]);
        mce_i = 1'b1; mwe_i = 1'b1; munit_i = 2'd3; msign_i = 1'b0;
        maddr_i = 64'h8000_0020; wmdata_i = 64'hCAFE_F00D_1234_5678;
        bus.req_ready_i = 1'b1;
        step();
        step();
        bus.req_ready_i = 1'b0;
        step();
        chk("pre_rst_stall", stall_o, 1'b1);
        rst   = 1'b0;
        mce_i = 1'b0;
        #1;
        chk("arst_rmdata", rmdata_o, 64'h0);
        chk("arst_err", err_o, 1'b0);
        chk("arst_req_valid", bus.req_valid_o, 1'b0);
        chk("arst_req_addr", bus.req_addr_o, 64'h0);
        chk("arst_req_we", bus.req_we_o, 1'b0);
        chk("arst_req_wstrb", bus.req_wstrb_o, 8'h00);
        chk("arst_req_wdata", bus.req_wdata_o, 64'h0);
        chk("arst_stall", stall_o, 1'b0);
        step();
        rst = 1'b1;
        bus.rsp_valid_i = 1'b1;
        bus.rsp_data_i  = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.rsp_err_i   = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("late_rsp_stall", stall_o, 1'b0);
            chk("late_rsp_rmdata", rmdata_o, 64'h0);
            chk("late_rsp_err", err_o, 1'b0);
        end
        bus.rsp_valid_i = 1'b0;
        bus.rsp_err_i   = 1'b0;
        run_txn(tbl[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22040895_dmem_ctrl.md
Name: ysyx_22040895_dmem_ctrl

Overview:
- Data-memory access controller downstream of the memory-stage unit.
- Consumes the stage's access enable, write enable, access size, address and store data.
- Runs a valid/ready request plus response transaction on the 64-bit data-memory bus, aligning store lanes and extracting/sign-extending load data.
- Stalls the pipeline until the access completes; flags misaligned accesses without touching the bus.

Parameters:
- XLEN, 64, data/address width (matches RegBus).
- TIMEOUT_CYC, 255, maximum cycles waited in RESP before an error completion.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (rst==0 resets)
- mce_i  in  1  access enable from memory stage
- mwe_i  in  1  1=store, 0=load (valid with mce_i)
- munit_i  in  2  size: 00 byte, 01 half, 10 word, 11 double
- msign_i  in  1  1=sign-extend load, 0=zero-extend
- maddr_i  in  XLEN  byte address
- wmdata_i  in  XLEN  store data, right-justified
- rmdata_o  out  XLEN  extended load data, valid in DONE
- stall_o  out  1  hold pipeline
- misalign_o  out  1  misaligned access flag
- err_o  out  1  bus error/timeout, valid in DONE
- req_valid_o  out  1  bus request valid
- req_ready_i  in  1  bus request accept
- req_addr_o  out  XLEN  maddr with [2:0] cleared
- req_we_o  out  1  store request
- req_wstrb_o  out  8  byte strobes
- req_wdata_o  out  XLEN  lane-aligned store data
- rsp_valid_i  in  1  response valid (loads and stores)
- rsp_data_i  in  XLEN  raw 8-byte read data
- rsp_err_i  in  1  response error

Behaviour:
- Reset (async, rst low): state=IDLE, timeout counter=0; every registered output 0 (rmdata_o, err_o, req_*). An in-flight transaction is abandoned; later rsp_valid_i is ignored because the block is in IDLE/REQ, not RESP.
- Misalignment (combinational): half with addr[0]!=0; word with addr[1:0]!=0; double with addr[2:0]!=0.
- IDLE:
  - mce_i=1 and aligned: latch addr, size, sign, we; compute strobe/data; next state REQ.
  - mce_i=1 and misaligned: misalign_o=1 this cycle, stall_o=0, no request, stay IDLE.
- REQ: req_valid_o=1; all req_* fields held stable until req_ready_i=1. On the handshake go to RESP and clear the counter. rsp_valid_i is ignored in REQ.
- RESP:
  - On rsp_valid_i, capture rmdata_o (extracted load, or 0 for a store) and err_o=rsp_err_i; go to DONE.
  - Counter increments each cycle. On reaching TIMEOUT_CYC without a response: err_o=1, rmdata_o=0, go to DONE.
- DONE: one cycle with stall_o=0 so the instruction retires; mce_i is ignored; go to IDLE.
- stall_o = (IDLE & mce_i & aligned) | REQ | RESP. Minimum access is 3 stall cycles plus the DONE cycle.
- Store lanes:
  - off = addr[2:0].
  - req_wdata_o = wmdata_i << (8*off).
  - req_wstrb_o = {01,03,0F,FF}[size] << off.
  - Loads drive wstrb=0.
- Load extract: (rsp_data_i >> 8*off) truncated to the size, then sign- or zero-extended to 64 bits per msign_i. Double ignores msign_i.
- err_o and rmdata_o hold until the next DONE.

Decomposition:
- Shared define header: size encodings (SZ_B/H/W/D), FSM state encodings (IDLE/REQ/RESP/DONE), TIMEOUT default.
- One combinational sub-module, ysyx_22040895_dmem_align, for strobe/data lane shifting, load extraction/extension and misalignment detection.
- FSM and counter live in the top.

Test Plan:
- Store byte addr 0x8000_0003, wmdata 0xAB, ready immediate, rsp after 1 cycle -> req_addr 0x8000_0000, wstrb 0x08, wdata 0xAB00_0000, stall high 3 cycles then DONE.
- Load half signed addr 0x8000_0006, rsp_data 0x8001_0000_0000_0000 -> rmdata_o 0xFFFF_FFFF_FFFF_8001; unsigned -> 0x0000_0000_0000_8001.
- Load word addr 0x8000_0002 -> misalign_o=1 one cycle, stall_o=0, req_valid_o never asserted.
- req_ready_i held low 5 cycles -> req_valid_o and fields stable for all 5 cycles; handshake on cycle 6.
- No rsp_valid_i for TIMEOUT_CYC cycles -> err_o=1, rmdata_o=0, DONE, then IDLE.
- rst low during RESP, then late rsp_valid_i -> all outputs 0, IDLE, response ignored, next access completes normally.
